// File: rtl/scoreboard_ctrl.sv
// Scoreboard write-port controller: in-order retire plus round-robin arbitration of
// alloc/opcode/completion requesters, with a walking flush that invalidates every entry.
module scoreboard_ctrl #(
    parameter int unsigned SCRBRD_SIZE  = 32,
    parameter int unsigned PC_WIDTH     = 32,
    parameter int unsigned OPCODE_WIDTH = 7,
    localparam int unsigned IDX_W       = $clog2(SCRBRD_SIZE)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    alloc_valid,
    input  logic [PC_WIDTH-1:0]     alloc_pc,
    output logic                    alloc_ready,
    output logic [IDX_W-1:0]        alloc_idx,
    input  logic                    op_valid,
    input  logic [IDX_W-1:0]        op_idx,
    input  logic [OPCODE_WIDTH-1:0] op_opcode,
    output logic                    op_ready,
    input  logic                    cmpl_valid,
    input  logic [IDX_W-1:0]        cmpl_idx,
    output logic                    cmpl_ready,
    input  logic                    flush,
    output logic [IDX_W-1:0]        sb_idx,
    output logic                    sb_pc_vld,
    output logic [PC_WIDTH-1:0]     sb_pc,
    output logic                    sb_opcode_vld,
    output logic [OPCODE_WIDTH-1:0] sb_opcode,
    output logic                    sb_completed_vld,
    output logic                    sb_invalidate_vld,
    output logic                    retire_vld,
    output logic [IDX_W-1:0]        retire_idx,
    output logic [IDX_W:0]          count,
    output logic                    full,
    output logic                    empty,
    output logic                    flush_busy,
    output logic                    err_bad_idx
);

    typedef enum logic {StRun, StFlush} state_e;

    localparam logic [IDX_W-1:0] IdxOne  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IdxLast = IDX_W'(SCRBRD_SIZE - 1);
    localparam logic [IDX_W:0]   CntOne  = (IDX_W + 1)'(1);
    localparam logic [IDX_W:0]   CntFull = (IDX_W + 1)'(SCRBRD_SIZE);

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        head_q, head_d, tail_q, tail_d, walk_q, walk_d;
    logic [IDX_W:0]          count_q, count_d;
    logic [SCRBRD_SIZE-1:0]  vld_q, vld_d, cmpl_q, cmpl_d;
    logic [1:0]              rr_q, rr_d;  // 0: cmpl, 1: op, 2: alloc
    logic                    err_q, err_d;
    logic [IDX_W-1:0]        sb_idx_q, sb_idx_d, retire_idx_q, retire_idx_d;
    logic                    sb_pc_vld_q, sb_pc_vld_d, sb_opcode_vld_q, sb_opcode_vld_d;
    logic                    sb_completed_vld_q, sb_completed_vld_d;
    logic                    sb_invalidate_vld_q, sb_invalidate_vld_d;
    logic                    retire_vld_q, retire_vld_d;
    logic [PC_WIDTH-1:0]     sb_pc_q, sb_pc_d;
    logic [OPCODE_WIDTH-1:0] sb_opcode_q, sb_opcode_d;

    logic       run_ok, retire_go, rr_en;
    logic [2:0] req, gnt;

    assign full      = (count_q == CntFull);
    assign run_ok    = (state_q == StRun) && !flush;
    assign retire_go = run_ok && vld_q[head_q] && cmpl_q[head_q];
    assign rr_en     = run_ok && !retire_go;
    assign req       = {alloc_valid && !full, op_valid, cmpl_valid};

    // Priority order starts at the requester after the previous RR winner.
    always_comb begin
        gnt = 3'b000;
        if (rr_en) begin
            unique case (rr_q)
                2'd1: begin
                    if (req[1])      gnt = 3'b010;
                    else if (req[2]) gnt = 3'b100;
                    else if (req[0]) gnt = 3'b001;
                end
                2'd2: begin
                    if (req[2])      gnt = 3'b100;
                    else if (req[0]) gnt = 3'b001;
                    else if (req[1]) gnt = 3'b010;
                end
                default: begin
                    if (req[0])      gnt = 3'b001;
                    else if (req[1]) gnt = 3'b010;
                    else if (req[2]) gnt = 3'b100;
                end
            endcase
        end
    end

    assign cmpl_ready = gnt[0];
    assign op_ready   = gnt[1];
    assign alloc_ready = gnt[2];
    assign alloc_idx  = tail_q;

    always_comb begin
        state_d             = state_q;
        head_d              = head_q;
        tail_d              = tail_q;
        walk_d              = walk_q;
        count_d             = count_q;
        vld_d               = vld_q;
        cmpl_d              = cmpl_q;
        rr_d                = rr_q;
        err_d               = err_q;
        sb_idx_d            = '0;
        sb_pc_vld_d         = 1'b0;
        sb_pc_d             = '0;
        sb_opcode_vld_d     = 1'b0;
        sb_opcode_d         = '0;
        sb_completed_vld_d  = 1'b0;
        sb_invalidate_vld_d = 1'b0;
        retire_vld_d        = 1'b0;
        retire_idx_d        = '0;

        if (state_q == StRun) begin
            if (flush) begin
                state_d = StFlush;
                walk_d  = '0;
            end else if (retire_go) begin
                vld_d[head_q]       = 1'b0;
                head_d              = head_q + IdxOne;
                count_d             = count_q - CntOne;
                sb_idx_d            = head_q;
                sb_invalidate_vld_d = 1'b1;
                retire_vld_d        = 1'b1;
                retire_idx_d        = head_q;
            end else if (gnt[0]) begin
                cmpl_d[cmpl_idx]   = 1'b1;
                sb_idx_d           = cmpl_idx;
                sb_completed_vld_d = 1'b1;
                rr_d               = 2'd1;
                if (!vld_q[cmpl_idx]) err_d = 1'b1;
            end else if (gnt[1]) begin
                sb_idx_d        = op_idx;
                sb_opcode_vld_d = 1'b1;
                sb_opcode_d     = op_opcode;
                rr_d            = 2'd2;
                if (!vld_q[op_idx]) err_d = 1'b1;
            end else if (gnt[2]) begin
                vld_d[tail_q]  = 1'b1;
                cmpl_d[tail_q] = 1'b0;
                tail_d         = tail_q + IdxOne;
                count_d        = count_q + CntOne;
                sb_idx_d       = tail_q;
                sb_pc_vld_d    = 1'b1;
                sb_pc_d        = alloc_pc;
                rr_d           = 2'd0;
            end
        end else begin
            vld_d[walk_q]       = 1'b0;
            cmpl_d[walk_q]      = 1'b0;
            sb_idx_d            = walk_q;
            sb_invalidate_vld_d = 1'b1;
            walk_d              = walk_q + IdxOne;
            if (walk_q == IdxLast) begin
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
                state_d = StRun;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q             <= StRun;
            head_q              <= '0;
            tail_q              <= '0;
            walk_q              <= '0;
            count_q             <= '0;
            vld_q               <= '0;
            cmpl_q              <= '0;
            rr_q                <= 2'd0;
            err_q               <= 1'b0;
            sb_idx_q            <= '0;
            sb_pc_vld_q         <= 1'b0;
            sb_pc_q             <= '0;
            sb_opcode_vld_q     <= 1'b0;
            sb_opcode_q         <= '0;
            sb_completed_vld_q  <= 1'b0;
            sb_invalidate_vld_q <= 1'b0;
            retire_vld_q        <= 1'b0;
            retire_idx_q        <= '0;
        end else begin
            state_q             <= state_d;
            head_q              <= head_d;
            tail_q              <= tail_d;
            walk_q              <= walk_d;
            count_q             <= count_d;
            vld_q               <= vld_d;
            cmpl_q              <= cmpl_d;
            rr_q                <= rr_d;
            err_q               <= err_d;
            sb_idx_q            <= sb_idx_d;
            sb_pc_vld_q         <= sb_pc_vld_d;
            sb_pc_q             <= sb_pc_d;
            sb_opcode_vld_q     <= sb_opcode_vld_d;
            sb_opcode_q         <= sb_opcode_d;
            sb_completed_vld_q  <= sb_completed_vld_d;
            sb_invalidate_vld_q <= sb_invalidate_vld_d;
            retire_vld_q        <= retire_vld_d;
            retire_idx_q        <= retire_idx_d;
        end
    end

    assign sb_idx            = sb_idx_q;
    assign sb_pc_vld         = sb_pc_vld_q;
    assign sb_pc             = sb_pc_q;
    assign sb_opcode_vld     = sb_opcode_vld_q;
    assign sb_opcode         = sb_opcode_q;
    assign sb_completed_vld  = sb_completed_vld_q;
    assign sb_invalidate_vld = sb_invalidate_vld_q;
    assign retire_vld        = retire_vld_q;
    assign retire_idx        = retire_idx_q;
    assign count             = count_q;
    assign empty             = (count_q == '0);
    assign flush_busy        = (state_q == StFlush);
    assign err_bad_idx       = err_q;

endmodule
